bp_tlb_assoc: RTL and testbench

//  Fully-associative, ASID-tagged translation cache for the FE/BE MMUs, the parametrised successor
//  of the single-tag TLB. It adds per-entry ASID and global bit, a selective flush (all / ASID /

---
 rtl/bp_tlb_assoc.sv | 174 +++++++++++++++++
 tb/tb_bp_tlb_assoc.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_tlb_assoc.sv
// Fully-associative, ASID-tagged TLB with selective flush and duplicate-free fills.
// Optional BP_TLB_PLRU_EN selects tree pseudo-LRU replacement; default is round-robin.
module bp_tlb_assoc #(
  parameter int unsigned els_p         = 8,
  parameter int unsigned vtag_width_p  = 27,
  parameter int unsigned asid_width_p  = 9,
  parameter int unsigned entry_width_p = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     r_v_i,
  input  logic [vtag_width_p-1:0]  r_vtag_i,
  input  logic [asid_width_p-1:0]  r_asid_i,
  input  logic                     w_v_i,
  input  logic [vtag_width_p-1:0]  w_vtag_i,
  input  logic [asid_width_p-1:0]  w_asid_i,
  input  logic                     w_global_i,
  input  logic [entry_width_p-1:0] w_entry_i,
  input  logic                     flush_v_i,
  input  logic [1:0]               flush_mode_i,
  input  logic [vtag_width_p-1:0]  flush_vtag_i,
  input  logic [asid_width_p-1:0]  flush_asid_i,
  output logic                     v_o,
  output logic                     miss_v_o,
  output logic [entry_width_p-1:0] entry_o
);

  localparam int unsigned LgEls = $clog2(els_p);

  logic [els_p-1:0]         valid_q, valid_d, global_q;
  logic [vtag_width_p-1:0]  tag_q   [els_p];
  logic [asid_width_p-1:0]  asid_q  [els_p];
  logic [entry_width_p-1:0] data_q  [els_p];
  logic                     v_q, miss_q;
  logic [entry_width_p-1:0] entry_q, entry_d;

  logic [els_p-1:0] r_match, w_match, flush_hit, valid_post;
  logic [LgEls-1:0] r_idx, w_match_idx, inv_idx, victim_idx, w_idx;
  logic             r_go, r_hit, w_hit, has_inv, flush_all;

  always_comb begin
    r_match   = '0;
    flush_hit = '0;
    for (int e = 0; e < els_p; e++) begin
      r_match[e] = valid_q[e] && (tag_q[e] == r_vtag_i) &&
                   (global_q[e] || (asid_q[e] == r_asid_i));
      unique case (flush_mode_i)
        2'd0:    flush_hit[e] = 1'b1;
        2'd1:    flush_hit[e] = !global_q[e] && (asid_q[e] == flush_asid_i);
        2'd2:    flush_hit[e] = (tag_q[e] == flush_vtag_i);
        default: flush_hit[e] = !global_q[e] && (asid_q[e] == flush_asid_i) &&
                                (tag_q[e] == flush_vtag_i);
      endcase
    end
  end

  // Flush acts on pre-fill state; the fill then searches the post-flush array.
  assign valid_post = flush_v_i ? (valid_q & ~flush_hit) : valid_q;
  assign flush_all  = flush_v_i && (flush_mode_i == 2'd0);
  assign r_go       = r_v_i && !flush_v_i;
  assign r_hit      = r_go && (|r_match);

  always_comb begin
    w_match     = '0;
    r_idx       = '0;
    w_match_idx = '0;
    inv_idx     = '0;
    for (int e = 0; e < els_p; e++) begin
      w_match[e] = valid_post[e] && (tag_q[e] == w_vtag_i) &&
                   (global_q[e] || (asid_q[e] == w_asid_i));
    end
    for (int e = 0; e < els_p; e++) begin
      if (r_match[e]) r_idx = r_idx | LgEls'(e);
      if (w_match[e]) w_match_idx = w_match_idx | LgEls'(e);
    end
    for (int e = els_p - 1; e >= 0; e--) begin
      if (!valid_post[e]) inv_idx = LgEls'(e);
    end
  end

  assign w_hit   = |w_match;
  assign has_inv = ~&valid_post;
  assign w_idx   = w_hit ? w_match_idx : (has_inv ? inv_idx : victim_idx);

`ifdef BP_TLB_PLRU_EN
  logic [els_p-2:0] plru_q, plru_d;

  // Node n has children 2n+1 (left) and 2n+2 (right); a bit of 1 points right.
  function automatic logic [els_p-2:0] plru_touch(input logic [els_p-2:0] s,
                                                  input logic [LgEls-1:0] e);
    logic [els_p-2:0] r;
    int unsigned      node;
    r    = s;
    node = 0;
    for (int l = LgEls - 1; l >= 0; l--) begin
      r[node] = ~e[l];
      node    = 2 * node + 1 + {31'd0, e[l]};
    end
    return r;
  endfunction

  always_comb begin
    int unsigned node;
    victim_idx = '0;
    node       = 0;
    for (int l = LgEls - 1; l >= 0; l--) begin
      victim_idx[l] = plru_q[node];
      node          = 2 * node + 1 + {31'd0, plru_q[node]};
    end
  end

  always_comb begin
    plru_d = flush_all ? '0 : plru_q;
    if (r_hit) plru_d = plru_touch(plru_d, r_idx);
    if (w_v_i) plru_d = plru_touch(plru_d, w_idx);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) plru_q <= '0;
    else         plru_q <= plru_d;
  end
`else
  logic [LgEls-1:0] rr_q, rr_d;

  assign victim_idx = rr_q;

  always_comb begin
    rr_d = flush_all ? '0 : rr_q;
    if (w_v_i && !w_hit && !has_inv) rr_d = rr_d + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rr_q <= '0;
    else         rr_q <= rr_d;
  end
`endif

  always_comb begin
    valid_d = valid_post;
    if (w_v_i) valid_d[w_idx] = 1'b1;
    entry_d = r_hit ? data_q[r_idx] : entry_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q  <= '0;
      global_q <= '0;
      v_q      <= 1'b0;
      miss_q   <= 1'b0;
      entry_q  <= '0;
      for (int e = 0; e < els_p; e++) begin
        tag_q[e]  <= '0;
        asid_q[e] <= '0;
        data_q[e] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      v_q     <= r_hit;
      miss_q  <= r_go && !(|r_match);
      entry_q <= entry_d;
      if (w_v_i) begin
        tag_q[w_idx]    <= w_vtag_i;
        asid_q[w_idx]   <= w_asid_i;
        global_q[w_idx] <= w_global_i;
        data_q[w_idx]   <= w_entry_i;
      end
    end
  end

  assign v_o      = v_q;
  assign miss_v_o = miss_q;
  assign entry_o  = entry_q;

endmodule

// File: tb/tb_bp_tlb_assoc.sv
// Self-checking bench for bp_tlb_assoc against a slot-level behavioural model.
module tb_bp_tlb_assoc;

  localparam int ELS = 8;
  localparam int LG  = $clog2(ELS);

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        r_v_i = 0, w_v_i = 0, w_global_i = 0, flush_v_i = 0;
  logic [26:0] r_vtag_i = 0, w_vtag_i = 0, flush_vtag_i = 0;
  logic [8:0]  r_asid_i = 0, w_asid_i = 0, flush_asid_i = 0;
  logic [31:0] w_entry_i = 0;
  logic [1:0]  flush_mode_i = 0;
  logic        v_o, miss_v_o;
  logic [31:0] entry_o;

  bp_tlb_assoc dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .r_v_i(r_v_i), .r_vtag_i(r_vtag_i), .r_asid_i(r_asid_i),
    .w_v_i(w_v_i), .w_vtag_i(w_vtag_i), .w_asid_i(w_asid_i),
    .w_global_i(w_global_i), .w_entry_i(w_entry_i),
    .flush_v_i(flush_v_i), .flush_mode_i(flush_mode_i),
    .flush_vtag_i(flush_vtag_i), .flush_asid_i(flush_asid_i),
    .v_o(v_o), .miss_v_o(miss_v_o), .entry_o(entry_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit        v;
    bit [26:0] tag;
    bit [8:0]  asid;
    bit        g;
    bit [31:0] data;
  } ent_t;

  ent_t      m[ELS];
  int        rr;
  bit        pl[ELS];
  bit        exp_v, exp_miss;
  bit [31:0] exp_entry;
  int        errors = 0;
  int        checks = 0;

  function automatic int mfind(input bit [26:0] tag, input bit [8:0] asid);
    for (int e = 0; e < ELS; e++)
      if (m[e].v && m[e].tag == tag && (m[e].g || m[e].asid == asid)) return e;
    return -1;
  endfunction

  // Tree PLRU: a node bit points toward the half holding the next victim.
  function automatic void touch(input int e);
    int node = 0;
    for (int l = LG - 1; l >= 0; l--) begin
      int b = (e >> l) & 1;
      pl[node] = (b == 0);
      node = 2 * node + 1 + b;
    end
  endfunction

  function automatic int victim();
`ifdef BP_TLB_PLRU_EN
    int node = 0, vv = 0;
    for (int l = 0; l < LG; l++) begin
      int b = pl[node] ? 1 : 0;
      vv = vv * 2 + b;
      node = 2 * node + 1 + b;
    end
    return vv;
`else
    return rr;
`endif
  endfunction

  function automatic void model_reset();
    for (int e = 0; e < ELS; e++) begin
      m[e].v = 0; m[e].tag = 0; m[e].asid = 0; m[e].g = 0; m[e].data = 0;
      pl[e] = 0;
    end
    rr = 0; exp_v = 0; exp_miss = 0; exp_entry = 0;
  endfunction

  // Drives one cycle of stimulus, advances the model, returns just after the edge.
  task automatic step(input bit r, input bit [26:0] rt, input bit [8:0] ra,
                      input bit w, input bit [26:0] wt, input bit [8:0] wa,
                      input bit wg, input bit [31:0] wd,
                      input bit f, input bit [1:0] fm, input bit [26:0] ft,
                      input bit [8:0] fa);
    int idx;
    r_v_i = r; r_vtag_i = rt; r_asid_i = ra;
    w_v_i = w; w_vtag_i = wt; w_asid_i = wa; w_global_i = wg; w_entry_i = wd;
    flush_v_i = f; flush_mode_i = fm; flush_vtag_i = ft; flush_asid_i = fa;
    exp_v = 0; exp_miss = 0;
    if (r && !f) begin
      idx = mfind(rt, ra);
      if (idx >= 0) begin
        exp_v = 1; exp_entry = m[idx].data; touch(idx);
      end else exp_miss = 1;
    end
    if (f) begin
      for (int e = 0; e < ELS; e++) begin
        bit hitf;
        case (fm)
          2'd0: hitf = 1;
          2'd1: hitf = !m[e].g && m[e].asid == fa;
          2'd2: hitf = m[e].tag == ft;
          default: hitf = !m[e].g && m[e].asid == fa && m[e].tag == ft;
        endcase
        if (hitf) m[e].v = 0;
      end
      if (fm == 2'd0) begin
        rr = 0;
        for (int e = 0; e < ELS; e++) pl[e] = 0;
      end
    end
    if (w) begin
      idx = mfind(wt, wa);
      if (idx < 0)
        for (int e = ELS - 1; e >= 0; e--) if (!m[e].v) idx = e;
      if (idx < 0) begin
        idx = victim();
        rr = (rr + 1) % ELS;
      end
      m[idx].v = 1; m[idx].tag = wt; m[idx].asid = wa; m[idx].g = wg; m[idx].data = wd;
      touch(idx);
    end
    @(posedge clk_i); #1;
    r_v_i = 0; w_v_i = 0; flush_v_i = 0;
  endtask

  task automatic lookup(input bit [26:0] t, input bit [8:0] a);
    step(1, t, a, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fill(input bit [26:0] t, input bit [8:0] a, input bit g, input bit [31:0] d);
    step(0, 0, 0, 1, t, a, g, d, 0, 0, 0, 0);
  endtask

  task automatic flush(input bit [1:0] fm, input bit [26:0] ft, input bit [8:0] fa);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, fm, ft, fa);
  endtask

  task automatic test_reset();
    model_reset();
    reset_i = 1;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({v_o, miss_v_o, entry_o} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b miss=%b entry=%h, need 0/0/0", v_o, miss_v_o, entry_o);
    end
    reset_i = 0;
    @(posedge clk_i); #1;
    lookup(27'h123, 9'd1);
    checks++;
    if (v_o !== 1'b0 || miss_v_o !== 1'b1 || entry_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_lookup_miss: got v=%b miss=%b entry=%h, need 0/1/0",
               v_o, miss_v_o, entry_o);
    end
  endtask

  task automatic test_fill_lookup();
    fill(27'h123, 9'd1, 0, 32'hA5A5_0001);
    checks++;
    if (v_o !== 1'b0 || miss_v_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_fill: got v=%b miss=%b, need 0/0", v_o, miss_v_o);
    end
    lookup(27'h123, 9'd1);
    checks++;
    if (v_o !== 1'b1 || miss_v_o !== 1'b0 || entry_o !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL hit_asid1: got v=%b miss=%b entry=%h, need 1/0/a5a50001", v_o, miss_v_o, entry_o);
    end
    lookup(27'h123, 9'd2);
    checks++;
    if (v_o !== 1'b0 || miss_v_o !== 1'b1 || entry_o !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL miss_asid2: got v=%b miss=%b entry=%h, need 0/1/a5a50001 (held)",
               v_o, miss_v_o, entry_o);
    end
  endtask

  task automatic test_global_flush();
    fill(27'h200, 9'd7, 1, 32'h0000_BEEF);
    flush(2'd1, 27'h0, 9'd3);
    lookup(27'h200, 9'd3);
    checks++;
    if (v_o !== 1'b1 || entry_o !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL global_survives_asid_flush: got v=%b entry=%h, need 1/0000beef", v_o, entry_o);
    end
    flush(2'd2, 27'h200, 9'd0);
    lookup(27'h200, 9'd3);
    checks++;
    if (v_o !== 1'b0 || miss_v_o !== 1'b1) begin
      errors++;
      $display("FAIL vtag_flush_drops_global: got v=%b miss=%b, need 0/1", v_o, miss_v_o);
    end
    lookup(27'h123, 9'd1);
    checks++;
    if (v_o !== exp_v || miss_v_o !== exp_miss || entry_o !== exp_entry) begin
      errors++;
      $display("FAIL other_entry_kept: got v=%b miss=%b entry=%h, need %b/%b/%h",
               v_o, miss_v_o, entry_o, exp_v, exp_miss, exp_entry);
    end
  endtask

  task automatic test_refill();
    fill(27'h55, 9'd4, 0, 32'h5555);
    fill(27'h123, 9'd1, 0, 32'h1111);
    lookup(27'h123, 9'd1);
    checks++;
    if (v_o !== 1'b1 || entry_o !== 32'h1111) begin
      errors++;
      $display("FAIL refill_value: got v=%b entry=%h, need 1/00001111", v_o, entry_o);
    end
    for (int e = 0; e < ELS; e++) begin
      if (m[e].v) begin
        lookup(m[e].tag, m[e].asid);
        checks++;
        if (v_o !== 1'b1 || entry_o !== exp_entry) begin
          errors++;
          $display("FAIL refill_keeps_slot%0d: got v=%b entry=%h, need 1/%h",
                   e, v_o, entry_o, exp_entry);
        end
      end
    end
  endtask

  task automatic test_replacement();
    flush(2'd0, 0, 0);
    for (int i = 0; i < ELS; i++) fill(27'h400 + 27'(i), 9'd1, 0, 32'hC000 + 32'(i));
`ifdef BP_TLB_PLRU_EN
    lookup(27'h400, 9'd1);
`endif
    fill(27'h400 + 27'(ELS), 9'd1, 0, 32'hC000 + 32'(ELS));
    for (int i = 0; i <= ELS; i++) begin
      lookup(27'h400 + 27'(i), 9'd1);
      checks++;
      if (v_o !== exp_v || miss_v_o !== exp_miss || entry_o !== exp_entry) begin
        errors++;
        $display("FAIL evict_tag%0d: got v=%b miss=%b entry=%h, need %b/%b/%h",
                 i, v_o, miss_v_o, entry_o, exp_v, exp_miss, exp_entry);
      end
    end
`ifndef BP_TLB_PLRU_EN
    lookup(27'h400, 9'd1);
    checks++;
    if (miss_v_o !== 1'b1) begin
      errors++;
      $display("FAIL rr_tag0_evicted: got miss=%b, need 1", miss_v_o);
    end
`endif
  endtask

  task automatic test_flush_fill_read();
    fill(27'h123, 9'd1, 0, 32'h1111);
    step(1, 27'h123, 9'd1, 1, 27'h300, 9'd1, 0, 32'h3333, 1, 2'd0, 0, 0);
    checks++;
    if (v_o !== 1'b0 || miss_v_o !== 1'b0) begin
      errors++;
      $display("FAIL read_suppressed_by_flush: got v=%b miss=%b, need 0/0", v_o, miss_v_o);
    end
    lookup(27'h123, 9'd1);
    checks++;
    if (miss_v_o !== 1'b1) begin
      errors++;
      $display("FAIL flushed_gone: got miss=%b, need 1", miss_v_o);
    end
    lookup(27'h300, 9'd1);
    checks++;
    if (v_o !== 1'b1 || entry_o !== 32'h3333) begin
      errors++;
      $display("FAIL fill_survives_flush: got v=%b entry=%h, need 1/00003333", v_o, entry_o);
    end
  endtask

  task automatic test_read_write_same_cycle();
    step(1, 27'h777, 9'd2, 1, 27'h777, 9'd2, 0, 32'h7777, 0, 0, 0, 0);
    checks++;
    if (miss_v_o !== 1'b1 || v_o !== 1'b0) begin
      errors++;
      $display("FAIL read_sees_prewrite: got v=%b miss=%b, need 0/1", v_o, miss_v_o);
    end
    lookup(27'h777, 9'd2);
    checks++;
    if (v_o !== 1'b1 || entry_o !== 32'h7777) begin
      errors++;
      $display("FAIL write_visible_next: got v=%b entry=%h, need 1/00007777", v_o, entry_o);
    end
  endtask

  task automatic test_reset_mid_lookup();
    r_v_i = 1; r_vtag_i = 27'h777; r_asid_i = 9'd2;
    #2 reset_i = 1;
    @(posedge clk_i); #1;
    r_v_i = 0;
    reset_i = 0;
    model_reset();
    @(posedge clk_i); #1;
    checks++;
    if (v_o !== 1'b0 || miss_v_o !== 1'b0 || entry_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_drops_pending: got v=%b miss=%b entry=%h, need 0/0/0",
               v_o, miss_v_o, entry_o);
    end
    lookup(27'h777, 9'd2);
    checks++;
    if (miss_v_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_clears_array: got miss=%b, need 1", miss_v_o);
    end
  endtask

  // Tags 10..11 are always global, others never, so lookups stay one-hot.
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit [26:0] rt, wt, ft;
      bit [8:0]  ra, wa, fa;
      bit        r, w, f;
      rt = 27'($urandom_range(0, 11)); ra = 9'($urandom_range(0, 3));
      wt = 27'($urandom_range(0, 11)); wa = 9'($urandom_range(0, 3));
      ft = 27'($urandom_range(0, 11)); fa = 9'($urandom_range(0, 3));
      r = $urandom_range(0, 1) == 1;
      w = $urandom_range(0, 2) == 0;
      f = $urandom_range(0, 15) == 0;
      step(r, rt, ra, w, wt, wa, wt >= 10, $urandom, f, 2'($urandom_range(0, 3)), ft, fa);
      checks++;
      if (v_o !== exp_v || miss_v_o !== exp_miss || entry_o !== exp_entry) begin
        errors++;
        $display("FAIL random_cycle%0d: got v=%b miss=%b entry=%h, need %b/%b/%h",
                 n, v_o, miss_v_o, entry_o, exp_v, exp_miss, exp_entry);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_lookup();
    test_global_flush();
    test_refill();
    test_replacement();
    test_flush_fill_read();
    test_read_write_same_cycle();
    test_reset_mid_lookup();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
